// File: rtl/hv_sram_scheduler.sv
// Per-modality SRAM bank sequencer for iM/projM triplets: encoder reads plus interleaved loader writes.
// Latency: read data valid SRAM_LAT cycles after the READ cycle; loader write lands the cycle after its handshake.
// Backpressure: reads win; LoadReady_SO low while the target modality is busy or requested (HVSCHED_STARVE_GUARD_EN adds a starvation override).
module hv_sram_scheduler #(
   parameter int NUM_MOD      = 3,
   parameter int ADDR_WIDTH   = 8,
   parameter int SRAM_LAT     = 1,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                             Clk_CI,
   input  logic                             Rst_RBI,
   input  logic [NUM_MOD-1:0]               ReadReq_SI,
   input  logic [NUM_MOD-1:0]               Advance_SI,
   input  logic [ADDR_WIDTH-1:0]            RdAddr_DI,
   input  logic                             LoadValid_SI,
   output logic                             LoadReady_SO,
   input  logic [$clog2(3*NUM_MOD)-1:0]     LoadBank_DI,
   input  logic [ADDR_WIDTH-1:0]            LoadAddr_DI,
   output logic [3*NUM_MOD-1:0]             BankCS_SO,
   output logic [3*NUM_MOD-1:0]             BankWE_SO,
   output logic [NUM_MOD*ADDR_WIDTH-1:0]    BankAddr_DO,
   output logic [3*NUM_MOD-1:0]             SramValid_SO
);

   localparam int NB = 3 * NUM_MOD;
   localparam int BW = $clog2(NB);
   localparam logic [1:0] WAIT_INIT = 2'(SRAM_LAT - 2);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_VALID, S_WRITE} state_t;

   logic [NUM_MOD-1:0] idle_vec;
   logic [NUM_MOD-1:0] load_hit;
   logic [NUM_MOD-1:0] load_fire;
   logic [1:0]         load_sub;
   logic               load_ok;
   logic               starve;

   // Decode the flat bank index into (modality, bank-within-triplet).
   always_comb begin
      load_hit = '0;
      load_sub = 2'd0;
      for (int m = 0; m < NUM_MOD; m++) begin
         for (int k = 0; k < 3; k++) begin
            if (LoadBank_DI == BW'(3 * m + k)) begin
               load_hit[m] = 1'b1;
               load_sub    = 2'(k);
            end
         end
      end
   end

   // Out-of-range banks are accepted and dropped so a bad loader cannot hang.
   assign load_ok      = (|load_hit) ? |(load_hit & idle_vec & (~ReadReq_SI | {NUM_MOD{starve}})) : 1'b1;
   assign LoadReady_SO = Rst_RBI & load_ok;
   assign load_fire    = {NUM_MOD{LoadValid_SI & LoadReady_SO}} & load_hit;

`ifdef HVSCHED_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_q;

   assign starve = (starve_q >= SW'(STARVE_LIMIT));

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         starve_q <= '0;
      end else if (LoadValid_SI && LoadReady_SO) begin
         starve_q <= '0;
      end else if (LoadValid_SI && !starve) begin
         starve_q <= starve_q + 1'b1;
      end
   end
`else
   assign starve = 1'b0;
`endif

   for (genvar m = 0; m < NUM_MOD; m++) begin : g_mod
      state_t                state_q;
      logic [ADDR_WIDTH-1:0] addr_q;
      logic [1:0]            sub_q;
      logic [1:0]            wait_q;

      always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
         if (!Rst_RBI) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sub_q   <= 2'd0;
            wait_q  <= 2'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  // Without the guard load_fire already implies no read request.
                  if (load_fire[m]) begin
                     state_q <= S_WRITE;
                     addr_q  <= LoadAddr_DI;
                     sub_q   <= load_sub;
                  end else if (ReadReq_SI[m]) begin
                     state_q <= S_READ;
                     addr_q  <= RdAddr_DI;
                  end
               end
               S_READ: begin
                  if (SRAM_LAT > 1) begin
                     state_q <= S_WAIT;
                     wait_q  <= WAIT_INIT;
                  end else begin
                     state_q <= S_VALID;
                  end
               end
               S_WAIT: begin
                  if (wait_q == 2'd0) state_q <= S_VALID;
                  else                wait_q  <= wait_q - 2'd1;
               end
               S_VALID: begin
                  if (Advance_SI[m] || !ReadReq_SI[m]) state_q <= S_IDLE;
               end
               S_WRITE: state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end

      assign idle_vec[m] = (state_q == S_IDLE);

      assign BankCS_SO[3*m +: 3]    = (state_q == S_READ)  ? 3'b111 :
                                      (state_q == S_WRITE) ? (3'b001 << sub_q) : 3'b000;
      assign BankWE_SO[3*m +: 3]    = (state_q == S_WRITE) ? (3'b001 << sub_q) : 3'b000;
      assign SramValid_SO[3*m +: 3] = (state_q == S_VALID) ? 3'b111 : 3'b000;
      assign BankAddr_DO[m*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
   end

endmodule
